// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Round-robin arbiter with frame locking that shares one 8N1
//               UART transmit line between NUM_REQ byte-stream requesters.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter  int NUM_REQ      = 2,
    parameter  int CLKS_PER_BIT = 434,
    parameter  int STOP_BITS    = 1,
    parameter  int LOCK_TIMEOUT = 1024,
    localparam int GW           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 io_systemClk,
    input  logic                 io_asyncResetn,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 txd,
    output logic                 busy,
    output logic [GW-1:0]        grant_id,
    output logic                 lock_active
);

    localparam int c_BW = $clog2(CLKS_PER_BIT + 1);
    localparam int c_LW = $clog2(LOCK_TIMEOUT + 1);

    localparam logic [c_BW-1:0] c_BAUD_LAST = c_BW'(CLKS_PER_BIT - 1);
    localparam logic [c_BW-1:0] c_BAUD_ONE  = c_BW'(1);
    localparam logic [c_LW-1:0] c_LOCK_MAX  = c_LW'(LOCK_TIMEOUT);
    localparam logic [c_LW-1:0] c_LOCK_ONE  = c_LW'(1);
    localparam logic            c_STOP_LAST = (STOP_BITS == 2);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_START = 2'd1;
    localparam logic [1:0] c_DATA  = 2'd2;
    localparam logic [1:0] c_STOP  = 2'd3;

    logic [1:0]         r_state;
    logic [c_BW-1:0]    r_baud;
    logic [2:0]         r_bit_idx;
    logic               r_stop_idx;
    logic [7:0]         r_shift;
    logic               r_txd;
    logic               r_busy;
    logic [GW-1:0]      r_grant;
    logic               r_lock;
    logic [c_LW-1:0]    r_lock_cnt;

    logic               w_idle;
    logic               w_lock_expired;
    logic               w_locked;
    logic               w_found;
    logic [GW-1:0]      w_cand;
    logic [GW-1:0]      w_idx;
    logic [7:0]         w_byte;
    logic               w_last;
    logic [NUM_REQ-1:0] w_ready;
    logic               w_accept;

    assign w_idle         = (r_state == c_IDLE);
    // Once the idle counter has hit its limit the lock no longer restricts
    // arbitration, so another requester can win on the same edge it clears.
    assign w_lock_expired = (r_lock_cnt == c_LOCK_MAX);
    assign w_locked       = r_lock && !w_lock_expired;
    assign w_accept       = w_idle && w_found;

    // Candidate search; r_grant doubles as the round-robin pointer.
    always_comb begin
        w_found = 1'b0;
        w_cand  = '0;
        w_idx   = '0;
        if (w_locked) begin
            if (req_valid[r_grant]) begin
                w_found = 1'b1;
                w_cand  = r_grant;
            end
        end else begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                w_idx = GW'((int'(r_grant) + k) % NUM_REQ);
                if (!w_found && req_valid[w_idx]) begin
                    w_found = 1'b1;
                    w_cand  = w_idx;
                end
            end
        end
    end

    always_comb begin
        w_byte  = '0;
        w_last  = 1'b0;
        w_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_cand == GW'(i)) begin
                w_byte = req_data[8*i +: 8];
                w_last = req_last[i];
            end
            w_ready[i] = w_idle && w_found && (w_cand == GW'(i));
        end
    end

    always_ff @(posedge io_systemClk or negedge io_asyncResetn) begin
        if (!io_asyncResetn) begin
            r_state    <= c_IDLE;
            r_baud     <= '0;
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
            r_shift    <= '0;
            r_txd      <= 1'b1;
            r_busy     <= 1'b0;
            r_grant    <= '0;
            r_lock     <= 1'b0;
            r_lock_cnt <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_shift    <= w_byte;
                        r_grant    <= w_cand;
                        r_lock     <= ~w_last;
                        r_lock_cnt <= '0;
                        r_baud     <= '0;
                        r_txd      <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= c_START;
                    end else if (r_lock) begin
                        if (req_valid[r_grant]) begin
                            r_lock_cnt <= '0;
                        end else if (w_lock_expired) begin
                            r_lock     <= 1'b0;
                            r_lock_cnt <= '0;
                        end else begin
                            r_lock_cnt <= r_lock_cnt + c_LOCK_ONE;
                        end
                    end
                end
                c_START: begin
                    if (r_baud == c_BAUD_LAST) begin
                        r_baud    <= '0;
                        r_bit_idx <= '0;
                        r_txd     <= r_shift[0];
                        r_state   <= c_DATA;
                    end else begin
                        r_baud <= r_baud + c_BAUD_ONE;
                    end
                end
                c_DATA: begin
                    if (r_baud == c_BAUD_LAST) begin
                        r_baud <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_stop_idx <= 1'b0;
                            r_txd      <= 1'b1;
                            r_state    <= c_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_txd     <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud + c_BAUD_ONE;
                    end
                end
                default: begin
                    if (r_baud == c_BAUD_LAST) begin
                        r_baud <= '0;
                        if (r_stop_idx == c_STOP_LAST) begin
                            r_busy  <= 1'b0;
                            r_state <= c_IDLE;
                        end else begin
                            r_stop_idx <= 1'b1;
                        end
                    end else begin
                        r_baud <= r_baud + c_BAUD_ONE;
                    end
                end
            endcase
        end
    end

    assign req_ready   = w_ready;
    assign txd         = r_txd;
    assign busy        = r_busy;
    assign grant_id    = r_grant;
    assign lock_active = r_lock;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Directed self-checking bench for uart_tx_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [1:0]  a_valid, a_last, a_ready;
    logic [15:0] a_data;
    logic        a_txd, a_busy, a_lock;
    logic [0:0]  a_gid;
    logic [1:0]  b_valid, b_last, b_ready;
    logic [15:0] b_data;
    logic        b_txd, b_busy, b_lock;
    logic [0:0]  b_gid;

    int checks = 0;
    int errors = 0;

    uart_tx_arbiter #(
        .NUM_REQ(2), .CLKS_PER_BIT(4), .STOP_BITS(1), .LOCK_TIMEOUT(8)
    ) u_dut_a (
        .io_systemClk(clk), .io_asyncResetn(rst_n),
        .req_valid(a_valid), .req_data(a_data), .req_last(a_last),
        .req_ready(a_ready), .txd(a_txd), .busy(a_busy),
        .grant_id(a_gid), .lock_active(a_lock)
    );

    uart_tx_arbiter #(
        .NUM_REQ(2), .CLKS_PER_BIT(1), .STOP_BITS(2), .LOCK_TIMEOUT(8)
    ) u_dut_b (
        .io_systemClk(clk), .io_asyncResetn(rst_n),
        .req_valid(b_valid), .req_data(b_data), .req_last(b_last),
        .req_ready(b_ready), .txd(b_txd), .busy(b_busy),
        .grant_id(b_gid), .lock_active(b_lock)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called on the falling edge just after the accepting edge; walks the
    // whole frame one cycle at a time and returns in the first idle cycle.
    task automatic frame(input bit sel, input logic [7:0] b);
        int   c, s, n, bit_no;
        logic e;
        c = sel ? 1 : 4;
        s = sel ? 2 : 1;
        n = (9 + s) * c;
        for (int k = 0; k < n; k++) begin
            bit_no = k / c;
            if (bit_no == 0)      e = 1'b0;
            else if (bit_no <= 8) e = b[bit_no-1];
            else                  e = 1'b1;
            check($sformatf("txd%0d_%02h_k%0d", sel, b, k), sel ? b_txd : a_txd, e);
            check($sformatf("busy%0d_%02h_k%0d", sel, b, k), sel ? b_busy : a_busy, 1);
            if (k == c)
                check($sformatf("ready_in_frame%0d_%02h", sel, b), sel ? b_ready : a_ready, 0);
            @(negedge clk);
        end
        check($sformatf("busy_end%0d_%02h", sel, b), sel ? b_busy : a_busy, 0);
        check($sformatf("txd_end%0d_%02h", sel, b), sel ? b_txd : a_txd, 1);
    endtask

    initial begin
        rst_n = 1'b0;
        a_valid = '0; a_data = '0; a_last = '0;
        b_valid = '0; b_data = '0; b_last = '0;
        repeat (3) @(negedge clk);
        check("rst_txd", a_txd, 1);
        check("rst_busy", a_busy, 0);
        check("rst_ready", a_ready, 0);
        check("rst_gid", a_gid, 0);
        check("rst_lock", a_lock, 0);
        check("rst_b_txd", b_txd, 1);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_txd", a_txd, 1);
        check("idle_busy", a_busy, 0);

        // Single byte 0x55 from req0, closes its own frame
        a_valid = 2'b01; a_data = 16'h0055; a_last = 2'b01;
        #1 check("t1_ready", a_ready, 2'b01);
        @(negedge clk);
        a_valid = 2'b00;
        check("t1_gid", a_gid, 0);
        check("t1_lock", a_lock, 0);
        frame(0, 8'h55);
        check("t1_ready_after", a_ready, 0);
        check("t1_lock_after", a_lock, 0);

        // Both requesters valid from reset: grants alternate 1,0,1,0
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        a_valid = 2'b11; a_data = 16'hC30F; a_last = 2'b11;
        for (int n = 0; n < 4; n++) begin
            #1 check($sformatf("t2_ready%0d", n), a_ready, (n % 2 == 0) ? 2'b10 : 2'b01);
            @(negedge clk);
            if (n == 3) a_valid = 2'b00;
            check($sformatf("t2_gid%0d", n), a_gid, (n % 2 == 0) ? 1 : 0);
            check($sformatf("t2_lock%0d", n), a_lock, 0);
            frame(0, (n % 2 == 0) ? 8'hC3 : 8'h0F);
        end

        // req0 three-byte frame holds the line against a waiting req1
        a_valid = 2'b01; a_data = 16'h2211; a_last = 2'b00;
        #1 check("t3_ready0", a_ready, 2'b01);
        @(negedge clk);
        a_valid = 2'b11; a_data = 16'h2212; a_last = 2'b10;
        check("t3_lock0", a_lock, 1);
        check("t3_gid0", a_gid, 0);
        frame(0, 8'h11);
        #1 check("t3_ready1", a_ready, 2'b01);
        @(negedge clk);
        a_data = 16'h2213; a_last = 2'b11;
        check("t3_lock1", a_lock, 1);
        frame(0, 8'h12);
        #1 check("t3_ready2", a_ready, 2'b01);
        @(negedge clk);
        a_valid = 2'b10;
        check("t3_lock2", a_lock, 0);
        check("t3_gid2", a_gid, 0);
        frame(0, 8'h13);
        #1 check("t3_ready3", a_ready, 2'b10);
        @(negedge clk);
        a_valid = 2'b00;
        check("t3_gid3", a_gid, 1);
        check("t3_lock3", a_lock, 0);
        frame(0, 8'h22);

        // req0 leaves its lock open and goes silent; req1 waits out the timeout
        a_valid = 2'b01; a_data = 16'h3C5A; a_last = 2'b10;
        #1 check("t4_ready0", a_ready, 2'b01);
        @(negedge clk);
        a_valid = 2'b10;
        check("t4_lock0", a_lock, 1);
        frame(0, 8'h5A);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t4_ready_locked%0d", i), a_ready, 2'b00);
            check($sformatf("t4_lock_held%0d", i), a_lock, 1);
            @(negedge clk);
        end
        check("t4_ready_expired", a_ready, 2'b10);
        @(negedge clk);
        a_valid = 2'b00;
        check("t4_lock_dropped", a_lock, 0);
        check("t4_gid", a_gid, 1);
        frame(0, 8'h3C);

        // Reset during data bit 3 of a 0x00 byte
        a_valid = 2'b01; a_data = 16'h0000; a_last = 2'b01;
        #1 check("t5_ready0", a_ready, 2'b01);
        @(negedge clk);
        a_valid = 2'b00;
        for (int k = 0; k < 17; k++) begin
            check($sformatf("t5_txd_k%0d", k), a_txd, 0);
            @(negedge clk);
        end
        check("t5_busy_pre", a_busy, 1);
        rst_n = 1'b0;
        #1;
        check("t5_txd_rst", a_txd, 1);
        check("t5_busy_rst", a_busy, 0);
        check("t5_gid_rst", a_gid, 0);
        check("t5_lock_rst", a_lock, 0);
        @(negedge clk);
        @(negedge clk);
        check("t5_txd_hold", a_txd, 1);
        rst_n = 1'b1;
        @(negedge clk);
        a_valid = 2'b10; a_data = 16'hA300; a_last = 2'b10;
        #1 check("t5_ready1", a_ready, 2'b10);
        @(negedge clk);
        a_valid = 2'b00;
        check("t5_gid1", a_gid, 1);
        frame(0, 8'hA3);

        // One-cycle bits, two stop bits, back-to-back 0xFF then 0x00
        b_valid = 2'b01; b_data = 16'h00FF; b_last = 2'b01;
        #1 check("t6_ready0", b_ready, 2'b01);
        @(negedge clk);
        b_data = 16'h0000;
        check("t6_gid0", b_gid, 0);
        frame(1, 8'hFF);
        check("t6_ready1", b_ready, 2'b01);
        @(negedge clk);
        b_valid = 2'b00;
        check("t6_lock1", b_lock, 0);
        frame(1, 8'h00);
        check("t6_ready_end", b_ready, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
